// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/writeback
// and drops into a sticky HALT on illegal opcodes or memory timeouts.
module multicycle_controller #(
    parameter int OPCODE_WIDTH    = 7,
    parameter int ALU_SRC_B_WIDTH = 2,
    parameter int MEM_TIMEOUT     = 15,
    parameter int TIMER_WIDTH     = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [OPCODE_WIDTH-1:0]    opcode,
    input  logic                       branch_taken,
    input  logic                       mem_ready,
    output logic                       pc_write,
    output logic                       ir_write,
    output logic                       reg_file_write,
    output logic                       alu_override,
    output logic                       alu_src_a,
    output logic [ALU_SRC_B_WIDTH-1:0] alu_src_b,
    output logic [1:0]                 reg_file_write_src,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic                       mem_addr_src,
    output logic                       fault,
    output logic [1:0]                 fault_code,
    output logic [3:0]                 state_dbg
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC_R = 4'd2,
        EXEC_I = 4'd3,
        EXEC_S = 4'd4,
        EXEC_B = 4'd5,
        EXEC_J = 4'd6,
        EXEC_U = 4'd7,
        MEM    = 4'd8,
        WB     = 4'd9,
        WB_MEM = 4'd10,
        HALT   = 4'd11
    } state_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_R     = OPCODE_WIDTH'(7'b0110011);
    localparam logic [OPCODE_WIDTH-1:0] OP_IMM   = OPCODE_WIDTH'(7'b0010011);
    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = OPCODE_WIDTH'(7'b0000011);
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(7'b0100011);
    localparam logic [OPCODE_WIDTH-1:0] OP_BR    = OPCODE_WIDTH'(7'b1100011);
    localparam logic [OPCODE_WIDTH-1:0] OP_JAL   = OPCODE_WIDTH'(7'b1101111);
    localparam logic [OPCODE_WIDTH-1:0] OP_LUI   = OPCODE_WIDTH'(7'b0110111);

    localparam logic [1:0] CODE_ILLEGAL = 2'd1;
    localparam logic [1:0] CODE_TIMEOUT = 2'd2;

    state_t                 state, next_state;
    logic [TIMER_WIDTH-1:0] wait_count;
    logic [1:0]             halt_code;
    logic                   timed_out;
    logic                   is_store;

    // mem_ready arriving on the last allowed count still wins over the timeout
    assign timed_out = (wait_count == TIMER_WIDTH'(MEM_TIMEOUT)) && !mem_ready;
    assign is_store  = (opcode == OP_STORE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Counter restarts on every entry into a memory-waiting state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_count <= '0;
        end else if ((next_state != state) && (next_state == FETCH || next_state == MEM)) begin
            wait_count <= '0;
        end else if ((state == FETCH || state == MEM) && !mem_ready) begin
            wait_count <= wait_count + TIMER_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fault_code <= 2'd0;
        end else if (state != HALT && next_state == HALT) begin
            fault_code <= halt_code;
        end
    end

    always_comb begin
        next_state         = state;
        halt_code          = 2'd0;
        pc_write           = 1'b0;
        ir_write           = 1'b0;
        reg_file_write     = 1'b0;
        alu_override       = 1'b0;
        alu_src_a          = 1'b0;
        alu_src_b          = '0;
        reg_file_write_src = 2'd0;
        mem_req            = 1'b0;
        mem_we             = 1'b0;
        mem_addr_src       = 1'b0;

        case (state)
            FETCH: begin
                mem_req      = 1'b1;
                alu_override = 1'b1;
                alu_src_b    = ALU_SRC_B_WIDTH'(2);
                ir_write     = mem_ready;
                if (mem_ready) begin
                    next_state = DECODE;
                end else if (timed_out) begin
                    next_state = HALT;
                    halt_code  = CODE_TIMEOUT;
                end
            end
            DECODE: begin
                pc_write = 1'b1;
                case (opcode)
                    OP_R:             next_state = EXEC_R;
                    OP_IMM, OP_LOAD:  next_state = EXEC_I;
                    OP_STORE:         next_state = EXEC_S;
                    OP_BR:            next_state = EXEC_B;
                    OP_JAL:           next_state = EXEC_J;
                    OP_LUI:           next_state = EXEC_U;
                    default: begin
                        next_state = HALT;
                        halt_code  = CODE_ILLEGAL;
                    end
                endcase
            end
            EXEC_R: begin
                alu_src_a  = 1'b1;
                next_state = WB;
            end
            EXEC_I, EXEC_S: begin
                alu_src_a  = 1'b1;
                alu_src_b  = ALU_SRC_B_WIDTH'(1);
                next_state = (opcode == OP_IMM) ? WB : MEM;
            end
            EXEC_B: begin
                alu_src_a  = 1'b1;
                pc_write   = branch_taken;
                next_state = FETCH;
            end
            EXEC_J: begin
                reg_file_write     = 1'b1;
                reg_file_write_src = 2'd2;
                pc_write           = 1'b1;
                next_state         = FETCH;
            end
            EXEC_U: begin
                alu_src_b  = ALU_SRC_B_WIDTH'(1);
                next_state = WB;
            end
            MEM: begin
                mem_req      = 1'b1;
                mem_addr_src = 1'b1;
                mem_we       = is_store;
                if (mem_ready) begin
                    next_state = (opcode == OP_LOAD) ? WB_MEM : FETCH;
                end else if (timed_out) begin
                    next_state = HALT;
                    halt_code  = CODE_TIMEOUT;
                end
            end
            WB: begin
                reg_file_write = 1'b1;
                next_state     = FETCH;
            end
            WB_MEM: begin
                reg_file_write     = 1'b1;
                reg_file_write_src = 2'd1;
                next_state         = FETCH;
            end
            HALT: begin
                next_state = HALT;
            end
            default: begin
                next_state = HALT;
                halt_code  = CODE_ILLEGAL;
            end
        endcase
    end

    assign fault     = (state == HALT);
    assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller with hand-computed state and
// control-signal expectations.
module tb_multicycle_controller;

    logic       clk;
    logic       rstn;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       reg_file_write;
    logic       alu_override;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] reg_file_write_src;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_src;
    logic       fault;
    logic [1:0] fault_code;
    logic [3:0] state_dbg;

    int checks   = 0;
    int failures = 0;

    multicycle_controller #(
        .OPCODE_WIDTH   (7),
        .ALU_SRC_B_WIDTH(2),
        .MEM_TIMEOUT    (15),
        .TIMER_WIDTH    (8)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .opcode            (opcode),
        .branch_taken      (branch_taken),
        .mem_ready         (mem_ready),
        .pc_write          (pc_write),
        .ir_write          (ir_write),
        .reg_file_write    (reg_file_write),
        .alu_override      (alu_override),
        .alu_src_a         (alu_src_a),
        .alu_src_b         (alu_src_b),
        .reg_file_write_src(reg_file_write_src),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr_src      (mem_addr_src),
        .fault             (fault),
        .fault_code        (fault_code),
        .state_dbg         (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rstn         = 1'b0;
        mem_ready    = 1'b0;
        branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Walk FETCH (mem_ready=1) and DECODE for the given opcode
    task automatic applyStimulus(input logic [6:0] op);
        opcode    = op;
        mem_ready = 1'b1;
        #1;
        checkOutput("fetch_state", state_dbg, 0);
        checkOutput("fetch_ir_write", ir_write, 1);
        tick();
        checkOutput("decode_state", state_dbg, 1);
        checkOutput("decode_pc_write", pc_write, 1);
        tick();
    endtask

    initial begin
        opcode       = 7'b0110011;
        rstn         = 1'b0;
        mem_ready    = 1'b0;
        branch_taken = 1'b0;
        #1;
        checkOutput("reset_state", state_dbg, 0);
        checkOutput("reset_mem_req", mem_req, 1);
        checkOutput("reset_fault", fault, 0);
        checkOutput("reset_fault_code", fault_code, 0);
        applyReset();

        // R-type: 0,1,2,9,0
        #1;
        checkOutput("r_fetch_alu_override", alu_override, 1);
        checkOutput("r_fetch_alu_src_b", alu_src_b, 2);
        checkOutput("r_fetch_rfw", reg_file_write, 0);
        applyStimulus(7'b0110011);
        checkOutput("r_exec_state", state_dbg, 2);
        checkOutput("r_exec_src_a", alu_src_a, 1);
        checkOutput("r_exec_src_b", alu_src_b, 0);
        checkOutput("r_exec_pc_write", pc_write, 0);
        checkOutput("r_exec_rfw", reg_file_write, 0);
        tick();
        checkOutput("r_wb_state", state_dbg, 9);
        checkOutput("r_wb_rfw", reg_file_write, 1);
        checkOutput("r_wb_src", reg_file_write_src, 0);
        checkOutput("r_wb_pc_write", pc_write, 0);
        tick();
        checkOutput("r_return_state", state_dbg, 0);

        // Load with mem_ready delayed 3 cycles in MEM
        applyStimulus(7'b0000011);
        checkOutput("ld_exec_state", state_dbg, 3);
        checkOutput("ld_exec_src_b", alu_src_b, 1);
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            checkOutput("ld_mem_wait_state", state_dbg, 8);
            checkOutput("ld_mem_req", mem_req, 1);
            checkOutput("ld_mem_addr_src", mem_addr_src, 1);
            checkOutput("ld_mem_we", mem_we, 0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        checkOutput("ld_mem_last_state", state_dbg, 8);
        tick();
        checkOutput("ld_wbmem_state", state_dbg, 10);
        checkOutput("ld_wbmem_rfw", reg_file_write, 1);
        checkOutput("ld_wbmem_src", reg_file_write_src, 1);
        tick();
        checkOutput("ld_return_state", state_dbg, 0);

        // ALU-immediate goes straight to WB
        applyStimulus(7'b0010011);
        checkOutput("imm_exec_state", state_dbg, 3);
        tick();
        checkOutput("imm_wb_state", state_dbg, 9);
        tick();

        // Branch not taken then taken
        for (int t = 0; t < 2; t++) begin
            applyStimulus(7'b1100011);
            branch_taken = (t == 1);
            #1;
            checkOutput("br_exec_state", state_dbg, 5);
            checkOutput("br_pc_write", pc_write, (t == 1) ? 1 : 0);
            checkOutput("br_src_a", alu_src_a, 1);
            tick();
            checkOutput("br_return_state", state_dbg, 0);
            branch_taken = 1'b0;
        end

        // JAL
        applyStimulus(7'b1101111);
        checkOutput("jal_state", state_dbg, 6);
        checkOutput("jal_rfw", reg_file_write, 1);
        checkOutput("jal_src", reg_file_write_src, 2);
        checkOutput("jal_pc_write", pc_write, 1);
        tick();
        checkOutput("jal_return_state", state_dbg, 0);

        // LUI
        applyStimulus(7'b0110111);
        checkOutput("lui_state", state_dbg, 7);
        checkOutput("lui_src_a", alu_src_a, 0);
        checkOutput("lui_src_b", alu_src_b, 1);
        tick();
        checkOutput("lui_wb_state", state_dbg, 9);
        tick();

        // Illegal opcode: HALT held 20 cycles, then async reset clears it
        applyStimulus(7'b1111111);
        for (int i = 0; i < 20; i++) begin
            checkOutput("ill_halt_state", state_dbg, 11);
            checkOutput("ill_fault", fault, 1);
            checkOutput("ill_fault_code", fault_code, 1);
            checkOutput("ill_mem_req", mem_req, 0);
            checkOutput("ill_pc_write", pc_write, 0);
            tick();
        end
        rstn = 1'b0;
        #1;
        checkOutput("ill_rst_state", state_dbg, 0);
        checkOutput("ill_rst_fault", fault, 0);
        checkOutput("ill_rst_fault_code", fault_code, 0);

        // FETCH timeout: 16 waiting cycles, then HALT with code 2
        applyReset();
        mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checkOutput("to_fetch_state", state_dbg, 0);
            tick();
        end
        checkOutput("to_halt_state", state_dbg, 11);
        checkOutput("to_fault", fault, 1);
        checkOutput("to_fault_code", fault_code, 2);

        // mem_ready on the 16th FETCH cycle still completes
        applyReset();
        mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        mem_ready = 1'b1;
        #1;
        checkOutput("late_fetch_state", state_dbg, 0);
        tick();
        checkOutput("late_decode_state", state_dbg, 1);
        checkOutput("late_fault", fault, 0);

        // Store interrupted by reset during MEM
        applyReset();
        applyStimulus(7'b0100011);
        checkOutput("st_exec_state", state_dbg, 4);
        checkOutput("st_exec_src_b", alu_src_b, 1);
        mem_ready = 1'b0;
        tick();
        checkOutput("st_mem_state", state_dbg, 8);
        checkOutput("st_mem_we", mem_we, 1);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("st_rst_state", state_dbg, 0);
        checkOutput("st_rst_mem_we", mem_we, 0);
        checkOutput("st_rst_mem_req", mem_req, 1);
        checkOutput("st_rst_fault", fault, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
